predsubtractor: RTL and testbench

- Encoder-side counterpart of the intra-loop prediction adder: forms the intra prediction for one square macroblock and streams out residue = original − prediction.
- Residue uses the modulo-256 arithmetic the decoder-side adder inverts, so reconstruction is bit-exact.
- Also accumulates the true SAD for mode decision.
- Sits between the original-pixel fetch and the transform/entropy path in IntraLoop.

---
 rtl/intra_pkg.sv | 21 ++
 rtl/predsub_dcacc.sv | 60 ++++++
 rtl/predsubtractor.sv | 174 +++++++++++++++++
 tb/tb_predsubtractor.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intra_pkg.sv
// Shared definitions for the IntraLoop prediction datapath: mode codes consumed
// by both the prediction adder and subtractor, FSM states and DC normalisation.
package intra_pkg;

  localparam logic [2:0] MODE_VERT = 3'd0;
  localparam logic [2:0] MODE_HORZ = 3'd1;
  localparam logic [2:0] MODE_DC   = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DCSUM,
    ST_STREAM,
    ST_DRAIN
  } state_t;

  // DC prediction averages the 2*mb_size neighbours with a plain shift.
  function automatic int dc_shift(input int mb_size);
    return $clog2(2 * mb_size);
  endfunction

endpackage

// File: rtl/predsub_dcacc.sv
// Sequential DC neighbour accumulator: one top+left pair per cycle, then a
// truncating shift produces the 8-bit DC predictor.
module predsub_dcacc
  import intra_pkg::*;
#(
  parameter int MB_SIZE  = 16,
  parameter int DC_SHIFT = dc_shift(MB_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [8*MB_SIZE-1:0] toppixels,
  input  logic [8*MB_SIZE-1:0] leftpixels,
  output logic                 done,
  output logic [7:0]           dc
);

  localparam int IW = $clog2(MB_SIZE);
  localparam logic [IW-1:0] IDX_MAX = IW'(MB_SIZE - 1);

  logic          running;
  logic [IW-1:0] idx;
  logic [12:0]   sum;
  logic [12:0]   sum_n;
  logic [7:0]    top_px;
  logic [7:0]    left_px;

  always_comb begin
    top_px  = toppixels[8*idx +: 8];
    left_px = leftpixels[8*idx +: 8];
    sum_n   = sum + 13'(top_px) + 13'(left_px);
  end

  // High during the final accumulation cycle; dc is valid from the next cycle.
  assign done = running && (idx == IDX_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      running <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      dc      <= '0;
    end else if (start) begin
      running <= 1'b1;
      idx     <= '0;
      sum     <= '0;
    end else if (running) begin
      sum <= sum_n;
      idx <= idx + 1'b1;
      if (done) begin
        running <= 1'b0;
        idx     <= '0;
        dc      <= 8'(sum_n >> DC_SHIFT);
      end
    end
  end

endmodule

// File: rtl/predsubtractor.sv
// Intra prediction subtractor: forms the macroblock prediction, streams
// residue = original - prediction (mod 256) and accumulates the block SAD.
module predsubtractor
  import intra_pkg::*;
#(
  parameter int MB_SIZE  = 16,
  parameter int DC_SHIFT = dc_shift(MB_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           mode,
  input  logic [8*MB_SIZE-1:0] toppixels,
  input  logic [8*MB_SIZE-1:0] leftpixels,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_pixel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_residue,
  output logic                 out_last,
  output logic                 done,
  output logic [15:0]          sad,
  output logic                 err
);

  localparam int CW = $clog2(MB_SIZE);
  localparam logic [CW-1:0] EDGE_MAX = CW'(MB_SIZE - 1);

  state_t               state;
  state_t               state_n;
  logic [2:0]           mode_q;
  logic [8*MB_SIZE-1:0] top_q;
  logic [8*MB_SIZE-1:0] left_q;
  logic [CW-1:0]        row;
  logic [CW-1:0]        col;
  logic [15:0]          sad_acc;
  logic [7:0]           dc;
  logic                 dc_done;
  logic                 accept;
  logic                 accept_dc;
  logic                 err_n;
  logic                 done_n;
  logic                 in_fire;
  logic                 out_fire;
  logic                 last_px;
  logic [7:0]           pred;
  logic [7:0]           residue;
  logic [7:0]           abs_diff;

  assign in_ready  = (state == ST_STREAM) && (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_px   = (row == EDGE_MAX) && (col == EDGE_MAX);
  assign accept_dc = accept && (mode == MODE_DC);

  predsub_dcacc #(
    .MB_SIZE  (MB_SIZE),
    .DC_SHIFT (DC_SHIFT)
  ) u_dcacc (
    .clk        (clk),
    .reset      (reset),
    .start      (accept_dc),
    .toppixels  (top_q),
    .leftpixels (left_q),
    .done       (dc_done),
    .dc         (dc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    err_n   = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (mode == MODE_VERT || mode == MODE_HORZ) begin
            accept  = 1'b1;
            state_n = ST_STREAM;
          end else if (mode == MODE_DC) begin
            accept  = 1'b1;
            state_n = ST_DCSUM;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ST_DCSUM:  if (dc_done) state_n = ST_STREAM;
      ST_STREAM: if (in_fire && last_px) state_n = ST_DRAIN;
      ST_DRAIN: begin
        if (out_fire) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    unique case (mode_q)
      MODE_VERT: pred = top_q[8*col +: 8];
      MODE_HORZ: pred = left_q[8*row +: 8];
      default:   pred = dc;
    endcase
    residue  = in_pixel - pred;
    abs_diff = (in_pixel >= pred) ? (in_pixel - pred) : (pred - in_pixel);
  end

  // NOTE: the latched neighbour registers are reset too, so an aborted
  // macroblock leaves no stale predictor state behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q  <= MODE_VERT;
      top_q   <= '0;
      left_q  <= '0;
      row     <= '0;
      col     <= '0;
      sad_acc <= '0;
    end else if (accept) begin
      mode_q  <= mode;
      top_q   <= toppixels;
      left_q  <= leftpixels;
      row     <= '0;
      col     <= '0;
      sad_acc <= '0;
    end else if (in_fire) begin
      sad_acc <= sad_acc + 16'(abs_diff);
      if (col == EDGE_MAX) begin
        col <= '0;
        row <= last_px ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Output register: a new input always wins over draining the old one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      out_residue <= '0;
      out_last    <= 1'b0;
    end else if (in_fire) begin
      out_valid   <= 1'b1;
      out_residue <= residue;
      out_last    <= last_px;
    end else if (out_fire) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done <= 1'b0;
      err  <= 1'b0;
      sad  <= '0;
    end else begin
      done <= done_n;
      err  <= err_n;
      if (done_n) sad <= sad_acc;
    end
  end

endmodule

// File: tb/tb_predsubtractor.sv
// Scoreboard bench for predsubtractor: a reference model queues expected
// residues and SADs, a negedge monitor compares them against the DUT.
module tb_predsubtractor;

  localparam int MB  = 16;
  localparam int NPX = MB * MB;

  typedef struct {
    logic [7:0] res;
    logic       last;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [2:0]      mode = 3'd0;
  logic [8*MB-1:0] toppixels = '0;
  logic [8*MB-1:0] leftpixels = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [7:0]      in_pixel = 8'd0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [7:0]      out_residue;
  logic            out_last;
  logic            done;
  logic [15:0]     sad;
  logic            err;

  predsubtractor #(.MB_SIZE(MB)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .toppixels   (toppixels),
    .leftpixels  (leftpixels),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pixel    (in_pixel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_residue (out_residue),
    .out_last    (out_last),
    .done        (done),
    .sad         (sad),
    .err         (err)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   sad_q[$];
  int   err_seen = 0;
  int   done_seen = 0;
  int   done_exp = 0;
  int   n_unexpected = 0;
  int   first_hs = -1;
  int   last_hs = -1;
  int   bp_mode = 0;
  int   gap_pct = 0;

  logic [7:0] top_a[MB];
  logic [7:0] left_a[MB];
  logic [7:0] orig_a[NPX];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic abort_run(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // Reference prediction straight from the mode definitions.
  function automatic int pred_of(input int m, input int r, input int c);
    int s = 0;
    if (m == 0) return int'(top_a[c]);
    if (m == 1) return int'(left_a[r]);
    for (int i = 0; i < MB; i++) s += int'(top_a[i]) + int'(left_a[i]);
    return s / (2 * MB);
  endfunction

  task automatic push_expect(input int m);
    int   s = 0;
    int   d;
    exp_t e;
    for (int p = 0; p < NPX; p++) begin
      d      = int'(orig_a[p]) - pred_of(m, p / MB, p % MB);
      e.res  = 8'((d + 256) % 256);
      e.last = (p == NPX - 1);
      exp_q.push_back(e);
      s += (d < 0) ? -d : d;
    end
    sad_q.push_back(s);
    done_exp++;
  endtask

  task automatic rand_fill();
    for (int i = 0; i < MB; i++) begin
      top_a[i]  = 8'($urandom_range(0, 255));
      left_a[i] = 8'($urandom_range(0, 255));
    end
    for (int p = 0; p < NPX; p++) orig_a[p] = 8'($urandom_range(0, 255));
  endtask

  // All driver tasks begin and end 1 time unit after a rising edge.
  task automatic start_mb(input logic [2:0] m);
    for (int i = 0; i < MB; i++) begin
      toppixels[8*i +: 8]  = top_a[i];
      leftpixels[8*i +: 8] = left_a[i];
    end
    mode  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int inj_at);
    int w;
    for (int p = 0; p < n; p++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_pixel = orig_a[p];
      if (p == inj_at) begin
        start = 1'b1;
        mode  = 3'd2;
        for (int i = 0; i < MB; i++) toppixels[8*i +: 8] = 8'($urandom_range(0, 255));
      end
      w = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        w++;
        if (w > 2000) abort_run("in_ready_wait");
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int w = 0;
    while (sad_q.size() != 0) begin
      @(negedge clk);
      w++;
      if (w > 3000) abort_run("done_wait");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = ($urandom_range(0, 99) < 60);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake and on done.
  logic [7:0] hold_res;
  logic       hold_last;
  logic       stalled = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      if (stalled) begin
        check("hold_valid", out_valid, 1);
        check("hold_residue", out_residue, hold_res);
        check("hold_last", out_last, hold_last);
      end
      stalled   = out_valid && !out_ready;
      hold_res  = out_residue;
      hold_last = out_last;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) n_unexpected++;
        else begin
          e = exp_q.pop_front();
          check("residue", out_residue, e.res);
          check("last", out_last, e.last);
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (done) begin
        done_seen++;
        if (sad_q.size() == 0) n_unexpected++;
        else begin
          check("sad", sad, sad_q.pop_front());
          check("done_timing", cyc, last_hs + 1);
        end
      end
      if (err) err_seen++;
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin : main
    int w;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_residue", out_residue, 0);
    check("rst_sad", sad, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Vertical, full throughput.
    for (int i = 0; i < MB; i++) begin
      top_a[i]  = 8'(i * 10);
      left_a[i] = 8'($urandom_range(0, 255));
    end
    for (int p = 0; p < NPX; p++) orig_a[p] = 8'd100;
    bp_mode = 0; gap_pct = 0; first_hs = -1;
    push_expect(0);
    start_mb(3'd0);
    feed(NPX, -1);
    wait_done();
    check("t1_throughput", last_hs - first_hs + 1, NPX);

    // DC: neighbour averaging takes one cycle per index.
    for (int i = 0; i < MB; i++) begin
      top_a[i]  = 8'd200;
      left_a[i] = 8'd100;
    end
    for (int p = 0; p < NPX; p++) orig_a[p] = 8'd150;
    push_expect(2);
    start_mb(3'd2);
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 200) abort_run("dcsum_wait");
    end
    check("t2_dcsum_cycles", w, MB);
    @(posedge clk); #1;
    feed(NPX, -1);
    wait_done();

    // Horizontal with alternating back-pressure.
    for (int i = 0; i < MB; i++) begin
      top_a[i]  = 8'($urandom_range(0, 255));
      left_a[i] = 8'(i);
    end
    for (int p = 0; p < NPX; p++) orig_a[p] = 8'd255;
    bp_mode = 1;
    push_expect(1);
    start_mb(3'd1);
    feed(NPX, -1);
    wait_done();

    // Illegal mode, then a start ignored mid-stream.
    start_mb(3'd5);
    @(negedge clk);
    check("t4_err_pulse", err, 1);
    check("t4_in_ready_idle", in_ready, 0);
    @(negedge clk);
    check("t4_err_one_cycle", err, 0);
    check("t4_still_idle", in_ready, 0);
    @(posedge clk); #1;
    rand_fill();
    bp_mode = 2; gap_pct = 20;
    push_expect(0);
    start_mb(3'd0);
    feed(NPX, 40);
    wait_done();

    // Reset mid-macroblock.
    rand_fill();
    bp_mode = 0; gap_pct = 0;
    push_expect(0);
    start_mb(3'd0);
    feed(37, -1);
    reset = 1'b0;
    #1;
    check("t5_out_valid", out_valid, 0);
    check("t5_sad", sad, 0);
    check("t5_in_ready", in_ready, 0);
    check("t5_done", done, 0);
    check("t5_out_last", out_last, 0);
    exp_q.delete();
    sad_q.delete();
    done_exp--;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    push_expect(0);
    start_mb(3'd0);
    feed(NPX, -1);
    wait_done();

    // Random round trips over all legal modes.
    for (int k = 0; k < 6; k++) begin
      logic [2:0] m;
      rand_fill();
      m       = 3'($urandom_range(0, 2));
      bp_mode = 2;
      gap_pct = $urandom_range(0, 30);
      push_expect(int'(m));
      start_mb(m);
      feed(NPX, -1);
      wait_done();
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("sad_queue_drained", sad_q.size(), 0);
    check("unexpected_outputs", n_unexpected, 0);
    check("err_pulses", err_seen, 1);
    check("done_pulses", done_seen, done_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
